// File: rtl/fila_escrita_reg_pkg.sv
// fila_escrita_reg_pkg
// Shared definitions for the writeback queue: data width, register index
// width, default queue depth and the queued entry layout {rd, data}.
package fila_escrita_reg_pkg;

    localparam int FILA_XLEN  = 32;
    localparam int FILA_REG_W = 5;
    localparam int FILA_PROF  = 4;

    typedef struct packed {
        logic [FILA_REG_W-1:0] rd;
        logic [FILA_XLEN-1:0]  data;
    } fila_entry_t;

endpackage

// File: rtl/fila_escrita_reg_mem.sv
// fila_mem
// Circular storage for the writeback queue. Entries are opaque EW-bit words.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_entry  enqueue wr_entry (ignored while full)
//   pop             dequeue the head (ignored while empty)
//   slot            whole storage array, for match logic in the parent
//   rd_ptr          index of the oldest entry
//   count           number of stored entries
//   full, empty     occupancy flags
module fila_mem #(
    parameter int PROF = 4,
    parameter int EW   = 37
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [EW-1:0]            wr_entry,
    output logic [EW-1:0]            slot [PROF],
    output logic [$clog2(PROF)-1:0]  rd_ptr,
    output logic [$clog2(PROF):0]    count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(PROF);
    localparam int CW = PW + 1;

    logic [EW-1:0] mem_q [PROF];
    logic [EW-1:0] mem_d [PROF];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(PROF));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // PROF is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage contents need no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign slot   = mem_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/fila_escrita_reg.sv
// fila_escrita_reg
// Writeback queue in front of the register file. Accepted writes are queued
// and drained one per cycle into a registered output stage that drives the
// register file write port. Decode-stage reads of a register with a pending
// write are flagged (hazard) or, with FILA_FORWARD_EN defined, forwarded.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_valid/wb_ready             request handshake, wb_rd/wb_data payload
//   rs1, rs2                      registers being read by decode
//   hazard1, hazard2              pending write to rs1/rs2 (0 with forwarding)
//   fwd1_*/fwd2_*                 forwarded value (FILA_FORWARD_EN only)
//   rd, writedataR, regiwrite     register file write port
//   count                         queued entries, output stage excluded
// Configuration macro: FILA_FORWARD_EN
module fila_escrita_reg
    import fila_escrita_reg_pkg::*;
#(
    parameter int PROF = FILA_PROF,
    parameter int XLEN = FILA_XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [FILA_REG_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic [FILA_REG_W-1:0]   rs1,
    input  logic [FILA_REG_W-1:0]   rs2,
    output logic                    hazard1,
    output logic                    hazard2,
`ifdef FILA_FORWARD_EN
    output logic                    fwd1_valid,
    output logic                    fwd2_valid,
    output logic [XLEN-1:0]         fwd1_data,
    output logic [XLEN-1:0]         fwd2_data,
`endif
    output logic [FILA_REG_W-1:0]   rd,
    output logic [XLEN-1:0]         writedataR,
    output logic                    regiwrite,
    output logic [$clog2(PROF):0]   count
);

    localparam int PW = $clog2(PROF);
    localparam int CW = PW + 1;
    localparam int EW = FILA_REG_W + XLEN;

    logic [EW-1:0]         slot [PROF];
    logic [EW-1:0]         head;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  full, empty, push, pop;

    logic [FILA_REG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  wr_q, wr_d;

    logic                  m1, m2;
    logic [XLEN-1:0]       f1, f2;
    logic [PW-1:0]         idx;

    assign wb_ready = !rst && !full;
    // Writes to x0 complete the handshake but are dropped here.
    assign push     = wb_valid && wb_ready && (wb_rd != '0);
    assign pop      = !empty;

    fila_mem #(.PROF(PROF), .EW(EW)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry ({wb_rd, wb_data}),
        .slot     (slot),
        .rd_ptr   (rd_ptr),
        .count    (cnt),
        .full     (full),
        .empty    (empty)
    );

    assign head = slot[rd_ptr];

    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        wr_d   = 1'b0;
        if (pop) begin
            rd_d   = head[EW-1:XLEN];
            data_d = head[XLEN-1:0];
            wr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            data_q <= data_d;
            wr_q   <= wr_d;
        end
    end

    // Scan oldest to youngest (output stage first) so the last hit is the
    // youngest pending value for each source register.
    always_comb begin
        m1  = 1'b0;
        m2  = 1'b0;
        f1  = '0;
        f2  = '0;
        idx = '0;
        if (wr_q && rd_q == rs1) begin
            m1 = 1'b1;
            f1 = data_q;
        end
        if (wr_q && rd_q == rs2) begin
            m2 = 1'b1;
            f2 = data_q;
        end
        for (int i = 0; i < PROF; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if (slot[idx][EW-1:XLEN] == rs1) begin
                    m1 = 1'b1;
                    f1 = slot[idx][XLEN-1:0];
                end
                if (slot[idx][EW-1:XLEN] == rs2) begin
                    m2 = 1'b1;
                    f2 = slot[idx][XLEN-1:0];
                end
            end
        end
        if (rst || rs1 == '0) m1 = 1'b0;
        if (rst || rs2 == '0) m2 = 1'b0;
    end

`ifdef FILA_FORWARD_EN
    assign fwd1_valid = m1;
    assign fwd2_valid = m2;
    assign fwd1_data  = f1;
    assign fwd2_data  = f2;
    assign hazard1    = 1'b0;
    assign hazard2    = 1'b0;
`else
    assign hazard1    = m1;
    assign hazard2    = m2;
`endif

    assign rd         = rd_q;
    assign writedataR = data_q;
    assign regiwrite  = wr_q;
    assign count      = cnt;

endmodule

// File: tb/tb_fila_escrita_reg.sv
module tb_fila_escrita_reg;

    localparam int PROF = 4;
    localparam int XLEN = 32;

    logic             clk;
    logic             rst;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [4:0]       rs1, rs2;
    logic             hazard1, hazard2;
`ifdef FILA_FORWARD_EN
    logic             fwd1_valid, fwd2_valid;
    logic [XLEN-1:0]  fwd1_data, fwd2_data;
`endif
    logic [4:0]       rd;
    logic [XLEN-1:0]  writedataR;
    logic             regiwrite;
    logic [2:0]       count;

    fila_escrita_reg #(.PROF(PROF), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
`ifdef FILA_FORWARD_EN
        .fwd1_valid (fwd1_valid),
        .fwd2_valid (fwd2_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
`endif
        .rd         (rd),
        .writedataR (writedataR),
        .regiwrite  (regiwrite),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus the last write
    // presented to the register file.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    logic            m_wr   = 1'b0;
    logic [4:0]      m_rd   = '0;
    logic [XLEN-1:0] m_data = '0;

    function automatic logic pending(input logic [4:0] r);
        if (rst || r == 0) return 1'b0;
        if (m_wr && m_rd == r) return 1'b1;
        foreach (q[i]) if (q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] youngest(input logic [4:0] r);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == r) return q[i].data;
        if (m_wr && m_rd == r) return m_data;
        return '0;
    endfunction

    task automatic compare();
        chk("count",      64'(count),      64'(q.size()));
        chk("wb_ready",   64'(wb_ready),   64'(!rst && q.size() < PROF));
        chk("regiwrite",  64'(regiwrite),  64'(m_wr));
        chk("rd",         64'(rd),         64'(m_rd));
        chk("writedataR", 64'(writedataR), 64'(m_data));
`ifdef FILA_FORWARD_EN
        chk("hazard1",    64'(hazard1),    64'(0));
        chk("hazard2",    64'(hazard2),    64'(0));
        chk("fwd1_valid", 64'(fwd1_valid), 64'(pending(rs1)));
        chk("fwd2_valid", 64'(fwd2_valid), 64'(pending(rs2)));
        if (pending(rs1)) chk("fwd1_data", 64'(fwd1_data), 64'(youngest(rs1)));
        if (pending(rs2)) chk("fwd2_data", 64'(fwd2_data), 64'(youngest(rs2)));
`else
        chk("hazard1",    64'(hazard1),    64'(pending(rs1)));
        chk("hazard2",    64'(hazard2),    64'(pending(rs2)));
`endif
    endtask

    task automatic model_edge();
        ent_t e;
        logic ready;
        if (rst) begin
            q.delete();
            m_wr = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            ready = (q.size() < PROF);
            if (q.size() > 0) begin
                e = q.pop_front();
                m_wr = 1'b1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_wr = 1'b0;
            end
            if (wb_valid && ready && wb_rd != 0) begin
                e.rd = wb_rd; e.data = wb_data;
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] wrd,
                        input logic [XLEN-1:0] wd, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst = r; wb_valid = v; wb_rd = wrd; wb_data = wd; rs1 = a; rs2 = b;
        #1;
        compare();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rs1 = '0; rs2 = '0;
        @(posedge clk);
        model_edge();
        step(1'b1, 1'b1, 5'd3, 32'h5555, 5'd3, 5'd0);

        // single write, two edges to the register file
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        idle(4);

        // back-to-back bursts while draining
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 5'(i), 32'(i * 16), 5'(i), 5'd0);
        idle(3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'(8 + i), 32'hA000 + 32'(i), 5'(8 + i), 5'(7 + i));
        idle(3);

        // write to x0 is swallowed
        step(1'b0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        idle(3);

        // two pending writes to the same register
        step(1'b0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd0);
        step(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd0);
        idle(2);

        // reset in the middle of a drain
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(20 + i), 32'hC0 + 32'(i), 5'(20 + i), 5'd21);
        step(1'b1, 1'b1, 5'd9, 32'h99, 5'd20, 5'd22);
        idle(4);

        // sustained push and pop across pointer wrap
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 5'(1 + (i % 31)), 32'hF000 + 32'(i), 5'(1 + (i % 31)), 5'(i % 31));
        idle(3);

        // random traffic with a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
